// File: rtl/draw_arbiter.sv
// draw_arbiter: shares one vga_adapter plot port among four rectangle
// requesters (0=loader, 1=ball, 2=brick, 3=platform). The winning
// requester's rectangle is raster-scanned one pixel per clock, with pixels
// off the visible screen suppressed. Completion is reported on done.
//
// Build option: define DRAW_ARB_RR_EN for round-robin arbitration. Without
// it, arbitration is fixed priority with index 0 highest.
//
// Handshake: a requester raises req[i] with its rect fields stable and holds
// them until it sees done[i] (a one-cycle pulse). Rect fields and erase are
// captured on the grant edge only. Dropping req mid-scan does not abort the
// scan. The requester may raise req again in the cycle after done.
module draw_arbiter #(
  parameter int COORD_W  = 10,
  parameter int DIM_W    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [3:0]           req,
  input  logic [4*COORD_W-1:0] rect_x,
  input  logic [4*COORD_W-1:0] rect_y,
  input  logic [4*DIM_W-1:0]   rect_w,
  input  logic [4*DIM_W-1:0]   rect_h,
  input  logic [11:0]          rect_colour,
  input  logic [3:0]           erase,
  output logic [3:0]           grant,
  output logic [3:0]           done,
  output logic                 busy,
  output logic [COORD_W-1:0]   x,
  output logic [COORD_W-1:0]   y,
  output logic [2:0]           colour,
  output logic                 writeEn
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Screen limits widened to the sum width so overflowed sums compare as off-screen.
  localparam logic [COORD_W:0] SCR_W = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SCR_H = (COORD_W+1)'(SCREEN_H);

  state_t             state;
  logic [COORD_W-1:0] x0, y0;
  logic [DIM_W-1:0]   w, h, cx, cy;
  logic [2:0]         col_lat;

  logic [1:0]         start, cand, win;
  logic               found;
  logic [DIM_W-1:0]   new_w, new_h;
  logic [COORD_W:0]   sx, sy;
  logic               last_col, last_row;

`ifdef DRAW_ARB_RR_EN
  logic [1:0]         rr_ptr;
  logic [1:0]         gidx;
  assign start = rr_ptr;
`else
  assign start = 2'd0;
`endif

  assign busy = (state != IDLE);

  // Pick the first requesting index, searching upward from start with wrap.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Scan datapath: pixel coordinates at one extra bit plus end-of-row/rect flags.
  always_comb begin
    new_w    = rect_w[win*DIM_W +: DIM_W];
    new_h    = rect_h[win*DIM_W +: DIM_W];
    sx       = {1'b0, x0} + {{(COORD_W+1-DIM_W){1'b0}}, cx};
    sy       = {1'b0, y0} + {{(COORD_W+1-DIM_W){1'b0}}, cy};
    last_col = (cx == w - DIM_W'(1));
    last_row = (cy == h - DIM_W'(1));
  end

  // Arbitration / scan FSM with registered plot and handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
      x0      <= '0;
      y0      <= '0;
      w       <= '0;
      h       <= '0;
      cx      <= '0;
      cy      <= '0;
      col_lat <= '0;
`ifdef DRAW_ARB_RR_EN
      rr_ptr  <= 2'd0;
      gidx    <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done    <= '0;
          writeEn <= 1'b0;
          if (found) begin
            grant   <= 4'(4'b0001 << win);
            x0      <= rect_x[win*COORD_W +: COORD_W];
            y0      <= rect_y[win*COORD_W +: COORD_W];
            w       <= new_w;
            h       <= new_h;
            col_lat <= erase[win] ? 3'b000 : rect_colour[win*3 +: 3];
            cx      <= '0;
            cy      <= '0;
`ifdef DRAW_ARB_RR_EN
            gidx    <= win;
`endif
            if (new_w == '0 || new_h == '0) begin
              // Empty rectangle: nothing to plot, report completion directly.
              state <= DONE;
`ifdef DRAW_ARB_RR_EN
              rr_ptr <= win + 2'd1;
`endif
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          x       <= sx[COORD_W-1:0];
          y       <= sy[COORD_W-1:0];
          colour  <= col_lat;
          // Off-screen pixels still take their cycle, only the strobe is masked.
          writeEn <= (sx < SCR_W) && (sy < SCR_H);
          if (last_col) begin
            cx <= '0;
            if (last_row) begin
              state <= DONE;
`ifdef DRAW_ARB_RR_EN
              rr_ptr <= gidx + 2'd1;
`endif
            end else begin
              cy <= cy + DIM_W'(1);
            end
          end else begin
            cx <= cx + DIM_W'(1);
          end
        end
        DONE: begin
          done    <= grant;
          grant   <= '0;
          writeEn <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Testbench for draw_arbiter: directed cases plus randomized batches, with a
// queue of expected plot/done events built from a rectangle-level model and
// a monitor that checks every writeEn strobe and done pulse against it.
module tb_draw_arbiter;

  localparam int CW = 10;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic [3:0]      req;
  logic [3:0]      erase;
  logic [CW-1:0]   rx [4];
  logic [CW-1:0]   ry [4];
  logic [DW-1:0]   rw [4];
  logic [DW-1:0]   rh [4];
  logic [2:0]      rc [4];
  logic [4*CW-1:0] rect_x, rect_y;
  logic [4*DW-1:0] rect_w, rect_h;
  logic [11:0]     rect_colour;
  logic [3:0]      grant, done;
  logic            busy, writeEn;
  logic [CW-1:0]   x, y;
  logic [2:0]      colour;

  always_comb begin
    rect_x = '0;
    rect_y = '0;
    rect_w = '0;
    rect_h = '0;
    rect_colour = '0;
    for (int i = 0; i < 4; i++) begin
      rect_x[i*CW +: CW] = rx[i];
      rect_y[i*CW +: CW] = ry[i];
      rect_w[i*DW +: DW] = rw[i];
      rect_h[i*DW +: DW] = rh[i];
      rect_colour[i*3 +: 3] = rc[i];
    end
  end

  draw_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_colour(rect_colour), .erase(erase),
    .grant(grant), .done(done), .busy(busy),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [25:0] exp_q[$];
  bit hold = 1'b0;
  bit scramble = 1'b1;
  int rr_m = 0;

  // Event word: {kind(1=done), requester, x, y, colour}
  function automatic logic [25:0] mk(input logic k, input logic [1:0] i,
                                     input logic [9:0] px, input logic [9:0] py,
                                     input logic [2:0] c);
    return {k, i, px, py, c};
  endfunction

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every strobe and done pulse must match the head of the queue.
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      if (writeEn) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pixel: unexpected strobe req=%0d x=%0d y=%0d col=%0d",
                   oh2i(grant), x, y, colour);
        end else begin
          logic [25:0] e;
          logic [25:0] a;
          e = exp_q.pop_front();
          a = mk(1'b0, oh2i(grant), x, y, colour);
          if (a !== e) begin
            miscompares++;
            $display("FAIL pixel: got k%0d r%0d (%0d,%0d) c%0d expected k%0d r%0d (%0d,%0d) c%0d",
                     a[25], a[24:23], a[22:13], a[12:3], a[2:0],
                     e[25], e[24:23], e[22:13], e[12:3], e[2:0]);
          end
        end
      end
      if (done != 4'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL done: unexpected done=%b", done);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          if (e[25] !== 1'b1 || done !== 4'(4'b0001 << e[24:23])) begin
            miscompares++;
            $display("FAIL done: got done=%b expected kind=%0d req=%0d", done, e[25], e[24:23]);
          end
        end
      end
      if ($countones(grant) > 1) begin
        miscompares++;
        $display("FAIL grant_onehot: got %b expected at most one bit", grant);
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected events for serving requester i: visible pixels row by row, then done.
  task automatic push_rect(input int i);
    logic [2:0] c;
    c = erase[i] ? 3'b000 : rc[i];
    for (int r = 0; r < int'(rh[i]); r++)
      for (int k = 0; k < int'(rw[i]); k++) begin
        int px, py;
        px = int'(rx[i]) + k;
        py = int'(ry[i]) + r;
        if (px < 160 && py < 120) exp_q.push_back(mk(1'b0, 2'(i), 10'(px), 10'(py), c));
      end
    exp_q.push_back(mk(1'b1, 2'(i), 10'd0, 10'd0, 3'd0));
    rr_m = (i + 1) % 4;
  endtask

  // Requests raised together and held until done are served in search order.
  task automatic model_batch(input logic [3:0] mask);
    int st;
`ifdef DRAW_ARB_RR_EN
    st = rr_m;
`else
    st = 0;
`endif
    for (int j = 0; j < 4; j++) begin
      int i;
      i = (st + j) % 4;
      if (mask[i]) push_rect(i);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_rect(input int i, input int px, input int py, input int pw,
                          input int ph, input logic [2:0] c, input logic e);
    rx[i] = CW'(px);
    ry[i] = CW'(py);
    rw[i] = DW'(pw);
    rh[i] = DW'(ph);
    rc[i] = c;
    erase[i] = e;
  endtask

  // One clock; requesters drop req on done and may change fields once granted.
  task automatic tick;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (scramble && grant[i]) begin
        rx[i] = CW'($urandom);
        ry[i] = CW'($urandom);
        rw[i] = DW'($urandom);
        rh[i] = DW'($urandom);
        rc[i] = 3'($urandom);
        erase[i] = 1'($urandom);
      end
      if (!hold && done[i]) req[i] = 1'b0;
    end
  endtask

  task automatic run_batch(input logic [3:0] mask);
    int t, lat, idx, area;
    bit single, seen;
    single = ($countones(mask) == 1);
    idx = int'(oh2i(mask));
    area = int'(rw[idx]) * int'(rh[idx]);
    lat = (area == 0) ? 2 : area + 2;
    model_batch(mask);
    req = mask;
    t = 0;
    seen = 1'b0;
    while ((req != 4'b0 || exp_q.size() != 0) && t < 400) begin
      tick();
      t++;
      if (single && t == 1) chk("grant_after_first_edge", grant, mask);
      if (single && !seen && done[idx]) begin
        seen = 1'b1;
        chk("done_latency", t, lat);
      end
    end
    if (t >= 400) begin
      miscompares++;
      $display("FAIL batch_timeout: got %0d pending expected 0 (mask %b)", exp_q.size(), mask);
      exp_q.delete();
      req = 4'b0;
    end
    tick();
  endtask

  function automatic int pick_coord(input int lo_edge);
    case ($urandom_range(0, 2))
      0: return $urandom_range(0, 20);
      1: return $urandom_range(lo_edge - 10, lo_edge + 5);
      default: return $urandom_range(1015, 1023);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    req = 4'b0;
    for (int i = 0; i < 4; i++) set_rect(i, 0, 0, 1, 1, 3'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {grant, done, busy, x, y, colour, writeEn}, 64'd0);
    resetn = 1'b1;
    tick();

    // Basic 2x2 scan.
    set_rect(1, 10, 20, 2, 2, 3'b010, 1'b0);
    run_batch(4'b0010);

    // Two simultaneous 1x1 requests.
    set_rect(1, 40, 40, 1, 1, 3'b101, 1'b0);
    set_rect(3, 50, 50, 1, 1, 3'b110, 1'b0);
    run_batch(4'b1010);

    // Right-edge clipping.
    set_rect(3, 158, 5, 4, 1, 3'b011, 1'b0);
    run_batch(4'b1000);

    // Zero-width rectangle.
    set_rect(2, 30, 30, 0, 3, 3'b111, 1'b0);
    run_batch(4'b0100);

    // Erase, then reset in the middle of the scan.
    set_rect(0, 5, 5, 3, 1, 3'b111, 1'b1);
    model_batch(4'b0001);
    req = 4'b0001;
    tick();
    tick();
    tick();
    #1;
    resetn = 1'b0;
    #1;
    chk("reset_abort_outputs", {grant, done, busy, x, y, colour, writeEn}, 64'd0);
    chk("pixels_before_reset", exp_q.size(), 2);
    exp_q.delete();
    rr_m = 0;
    req = 4'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_after_reset", {busy, grant}, 5'd0);
    end

`ifdef DRAW_ARB_RR_EN
    // All requests held: grants rotate 0,1,2,3,0.
    begin
      int st, gcount, t;
      logic [3:0] prev;
      hold = 1'b1;
      scramble = 1'b0;
      for (int i = 0; i < 4; i++) set_rect(i, i * 4, 0, 1, 1, 3'(i + 1), 1'b0);
      st = rr_m;
      for (int j = 0; j < 5; j++) push_rect((st + j) % 4);
      req = 4'b1111;
      gcount = 0;
      t = 0;
      prev = 4'b0;
      while (gcount < 5 && t < 200) begin
        tick();
        t++;
        if (grant != 4'b0 && prev == 4'b0) begin
          chk("rr_grant_order", grant, 4'(4'b0001 << ((st + gcount) % 4)));
          gcount++;
        end
        prev = grant;
      end
      req = 4'b0;
      hold = 1'b0;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
        tick();
        t++;
      end
      if (gcount < 5 || exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL rr_timeout: got %0d grants expected 5", gcount);
        exp_q.delete();
      end
      scramble = 1'b1;
      tick();
    end
`endif

    // Randomized batches.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        set_rect(i, pick_coord(160), pick_coord(120), $urandom_range(0, 5),
                 $urandom_range(0, 4), 3'($urandom), ($urandom_range(0, 3) == 0));
      run_batch(4'($urandom_range(1, 15)));
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
